work_sender: RTL and testbench

WORK_SENDER -- requirements
Module: work_sender

---
 rtl/work_sender.sv | 179 +++++++++++++++++
 tb/tb_work_sender.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/work_sender.sv
// -----------------------------------------------------------------------------
// work_sender
//   Serialises one work packet onto a UART 8N1 line. Byte k of the packet is
//   work[8k+7:8k], sent in order k = 0..PACKET_BYTES-1, LSB first. Frames of
//   one packet follow each other with no idle time between them. After the
//   last stop bit the line idles high for GAP_BITS bit-times before another
//   packet can be accepted.
//
//   Optional feature: define WORK_SENDER_ABORT_EN to add the abort input.
//   An abort while busy sends the line high and jumps to the closing gap,
//   which runs in full and ends without a done pulse. In the default build
//   the port and its logic are absent.
//
// Ports
//   clk         single clock for all logic
//   reset       synchronous, active-high reset
//   work        packet payload, captured only on an accepted load
//   load        single-cycle send request, accepted only while idle
//   abort       cancel the packet in flight (WORK_SENDER_ABORT_EN only)
//   TxD         UART line, idle high
//   busy        high from the cycle after an accepted load to the packet end
//   done        one-cycle pulse on the cycle busy falls after a full packet
//   byte_count  index of the byte on the line, 0 while idle
//
// Handshake: load is a request with no ready; it takes effect only in a cycle
// where busy is low, and any load seen while busy is high is dropped.
// -----------------------------------------------------------------------------
module work_sender #(
  parameter int CLOCK_RATE     = 25000000,
  parameter int UART_BAUD_RATE = 115200,
  parameter int PACKET_BYTES   = 80,
  parameter int GAP_BITS       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [8*PACKET_BYTES-1:0] work,
  input  logic                      load,
`ifdef WORK_SENDER_ABORT_EN
  input  logic                      abort,
`endif
  output logic                      TxD,
  output logic                      busy,
  output logic                      done,
  output logic [6:0]                byte_count
);

  localparam int DIV        = CLOCK_RATE / UART_BAUD_RATE;
  localparam int GAP_CYCLES = GAP_BITS * DIV;
  localparam int TIMER_MAX  = (GAP_CYCLES > DIV) ? GAP_CYCLES : DIV;
  localparam int TW         = $clog2(TIMER_MAX + 1);

  localparam logic [TW-1:0] BIT_LAST  = TW'(DIV - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [6:0]    BYTE_LAST = 7'(PACKET_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [TW-1:0]             timer;
  logic [2:0]                bit_idx;
  logic [8*PACKET_BYTES-1:0] payload;
  logic                      bit_end;
  logic                      gap_end;
  logic                      accept;
  logic                      force_gap;
  logic                      aborted;
  logic                      next_byte;

  assign bit_end   = (timer == BIT_LAST);
  assign gap_end   = (timer == GAP_LAST);
  assign accept    = (state == S_IDLE) && load;
  assign next_byte = (state == S_STOP) && (state_next == S_START);

`ifdef WORK_SENDER_ABORT_EN
  // Abort only redirects the frame states; a packet already in its gap just
  // finishes the gap. Abort in IDLE does nothing, so a load wins there.
  assign force_gap = abort && ((state == S_START) || (state == S_DATA) ||
                               (state == S_STOP));

  // Remembers that the packet in flight was cancelled so the gap ends quietly.
  always_ff @(posedge clk) begin
    if (reset) begin
      aborted <= 1'b0;
    end else if (accept) begin
      aborted <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      aborted <= 1'b1;
    end
  end
`else
  assign force_gap = 1'b0;
  assign aborted   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (load) state_next = S_START;
      S_START: if (bit_end) state_next = S_DATA;
      S_DATA:  if (bit_end && (bit_idx == 3'd7)) state_next = S_STOP;
      S_STOP:  if (bit_end) state_next = (byte_count == BYTE_LAST) ? S_GAP : S_START;
      S_GAP:   if (gap_end) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (force_gap) state_next = S_GAP;
  end

  // Output decode: the line level follows the state directly.
  always_comb begin
    TxD  = 1'b1;
    busy = (state != S_IDLE);
    case (state)
      S_START: TxD = 1'b0;
      S_DATA:  TxD = payload[bit_idx];
      default: TxD = 1'b1;
    endcase
  end

  // Datapath: bit timer, bit index, payload shifter, byte counter, done.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer      <= '0;
      bit_idx    <= '0;
      payload    <= '0;
      byte_count <= '0;
      done       <= 1'b0;
    end else begin
      // done lands on the first IDLE cycle, the same cycle busy drops.
      done <= (state == S_GAP) && gap_end && !aborted;

      // The timer restarts on every state change and on every data bit
      // boundary, so it never runs past one bit period (or one gap).
      if ((state == S_IDLE) || (state_next != state) ||
          ((state == S_DATA) && bit_end)) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end

      if (accept) begin
        bit_idx <= '0;
      end else if ((state == S_DATA) && bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end

      // The current byte is always payload[7:0]; shift in the next one as
      // the stop bit hands over to the following start bit.
      if (accept) begin
        payload <= work;
      end else if (next_byte) begin
        payload <= payload >> 8;
      end

      if (state_next == S_IDLE) begin
        byte_count <= '0;
      end else if (next_byte) begin
        byte_count <= byte_count + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_work_sender.sv
// -----------------------------------------------------------------------------
// tb_work_sender
//   Self-checking bench for work_sender at DIV = 4 (400 Hz clock, 100 baud),
//   80-byte packets and a 16-bit-time gap. Expected line/busy/done/byte_count
//   values come from a per-cycle packet model built from the frame rules, and
//   line contents are also decoded back into bytes like a UART receiver would.
// -----------------------------------------------------------------------------
module tb_work_sender;

  localparam int CLOCK_RATE = 400;
  localparam int BAUD       = 100;
  localparam int DIV        = CLOCK_RATE / BAUD;
  localparam int PB         = 80;
  localparam int GB         = 16;
  localparam int WORK_W     = 8 * PB;
  localparam int W          = 10;                    // {TxD, busy, done, byte_count}
  localparam int PKT_CYCLES = (10 * PB + GB) * DIV;  // 3264
  localparam int NO_LOAD    = -1;
  localparam int ALL        = 1 << 30;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b0;
  logic [WORK_W-1:0] work = '0;
`ifdef WORK_SENDER_ABORT_EN
  logic              abort = 1'b0;
`endif
  logic              TxD;
  logic              busy;
  logic              done;
  logic [6:0]        byte_count;

  always #5 clk = ~clk;

  work_sender #(
    .CLOCK_RATE    (CLOCK_RATE),
    .UART_BAUD_RATE(BAUD),
    .PACKET_BYTES  (PB),
    .GAP_BITS      (GB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .work      (work),
    .load      (load),
`ifdef WORK_SENDER_ABORT_EN
    .abort     (abort),
`endif
    .TxD       (TxD),
    .busy      (busy),
    .done      (done),
    .byte_count(byte_count)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         line_q[$];
  int           busy_cnt = 0;
  int           done_cnt = 0;
  int           vec_cnt  = 0;
  int           miss_cnt = 0;

  typedef struct {
    logic         rst;
    logic         ld;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[56];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic txd, input logic b, input logic d, input int bc);
    return {txd, b, d, 7'(bc)};
  endfunction

  function automatic logic [WORK_W-1:0] rand_work();
    logic [WORK_W-1:0] w;
    for (int i = 0; i < WORK_W / 32; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  // Whole-packet model: each byte is start, 8 data bits LSB first, stop, each
  // DIV cycles; then the gap; then one idle cycle carrying the done pulse.
  function automatic void push_packet(input logic [WORK_W-1:0] w);
    logic [7:0] b;
    for (int k = 0; k < PB; k++) begin
      b = w[8*k +: 8];
      for (int c = 0; c < DIV; c++) exp_q.push_back(pack(1'b0, 1'b1, 1'b0, k));
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < DIV; c++) exp_q.push_back(pack(b[i], 1'b1, 1'b0, k));
      for (int c = 0; c < DIV; c++) exp_q.push_back(pack(1'b1, 1'b1, 1'b0, k));
    end
    for (int c = 0; c < GB * DIV; c++) exp_q.push_back(pack(1'b1, 1'b1, 1'b0, PB - 1));
    exp_q.push_back(pack(1'b1, 1'b0, 1'b1, 0));
  endfunction

  function automatic void push_idle(input int n);
    for (int c = 0; c < n; c++) exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 0));
  endfunction

  // ---------------- driver ----------------
  // Checks up to max_n queued vectors, one per cycle on the falling edge.
  // After the check of index load_at, load is raised for one cycle with lw.
  task automatic drain(input int max_n, input int load_at, input logic [WORK_W-1:0] lw);
    int idx = 0;
    logic [W-1:0] e;
    while ((exp_q.size() > 0) && (idx < max_n)) begin
      @(negedge clk);
      load = 1'b0;
`ifdef WORK_SENDER_ABORT_EN
      abort = 1'b0;
`endif
      e = exp_q.pop_front();
      line_q.push_back(TxD);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      check("model", {TxD, busy, done, byte_count}, e);
      if (idx == load_at) begin
        load = 1'b1;
        work = lw;
      end
      idx++;
    end
  endtask

  // UART-style decode of the captured line, sampling each bit mid-period.
  task automatic decode_check(input int off, input logic [WORK_W-1:0] w);
    int pos;
    logic [9:0] got;
    pos = off;
    for (int k = 0; k < PB; k++) begin
      got[9] = line_q[pos + DIV / 2];
      for (int i = 0; i < 8; i++) got[i] = line_q[pos + DIV * (1 + i) + DIV / 2];
      got[8] = line_q[pos + DIV * 9 + DIV / 2];
      check("decode", got, {1'b0, 1'b1, w[8*k +: 8]});
      pos += 10 * DIV;
    end
  endtask

  task automatic start_packet(input logic [WORK_W-1:0] w);
    exp_q.delete();
    line_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    work = w;
    load = 1'b1;
  endtask

  // Directed-table expectation for spec cycle c of the 0xA5 sequence
  // (load during cycle 10, so the start bit occupies cycles 11..14).
  function automatic logic [W-1:0] tbl_exp(input int c);
    logic [7:0] a5;
    a5 = 8'hA5;
    if (c < 11)  return pack(1'b1, 1'b0, 1'b0, 0);
    if (c <= 14) return pack(1'b0, 1'b1, 1'b0, 0);
    if (c <= 46) return pack(a5[(c - 15) / DIV], 1'b1, 1'b0, 0);
    if (c <= 50) return pack(1'b1, 1'b1, 1'b0, 0);
    if (c == 51) return pack(1'b0, 1'b1, 1'b0, 1);
    return pack(1'b1, 1'b0, 1'b0, 0);
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [WORK_W-1:0] wa;
    logic [WORK_W-1:0] wb;
    int gap;
    int stray;

    // Table: entry j drives inputs during cycle j and checks cycle j+1.
    // Entry 1 has reset and load together (reset wins); entry 51 resets
    // in the middle of byte 1's start bit.
    for (int j = 0; j < 56; j++) begin
      tbl[j].rst = (j < 2) || (j == 51);
      tbl[j].ld  = (j == 1) || (j == 10);
      tbl[j].exp = tbl[j].rst ? pack(1'b1, 1'b0, 1'b0, 0) : tbl_exp(j + 1);
    end

    wa = rand_work();
    wa[7:0] = 8'hA5;
    work = wa;
    for (int j = 0; j < 56; j++) begin
      reset = tbl[j].rst;
      load  = tbl[j].ld;
      @(negedge clk);
      check("table", {TxD, busy, done, byte_count}, tbl[j].exp);
    end
    reset = 1'b0;
    load  = 1'b0;

    // Full packet: per-cycle model, busy length, single done, decoded bytes.
    wa = rand_work();
    start_packet(wa);
    push_packet(wa);
    push_idle(2);
    drain(ALL, NO_LOAD, '0);
    check("busy_cycles", busy_cnt, PKT_CYCLES);
    check("done_pulses", done_cnt, 1);
    decode_check(0, wa);

    // A load 1000 cycles into a packet is ignored.
    wa = rand_work();
    start_packet(wa);
    push_packet(wa);
    push_idle(1);
    drain(ALL, 1000, ~wa);
    check("ignored_load_done", done_cnt, 1);
    decode_check(0, wa);

    // Load in the done cycle: the next start bit follows immediately.
    wa = rand_work();
    wb = rand_work();
    start_packet(wa);
    push_packet(wa);
    push_packet(wb);
    push_idle(1);
    drain(ALL, PKT_CYCLES, wb);
    check("b2b_busy_cycles", busy_cnt, 2 * PKT_CYCLES);
    check("b2b_done_pulses", done_cnt, 2);
    decode_check(0, wa);
    decode_check(PKT_CYCLES + 1, wb);

    // Reset at byte 40, mid data bit 3.
    wa = rand_work();
    start_packet(wa);
    push_packet(wa);
    drain(40 * 10 * DIV + DIV + 3 * DIV + 3, NO_LOAD, '0);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid", {TxD, busy, done, byte_count}, pack(1'b1, 1'b0, 1'b0, 0));
    reset = 1'b0;
    done_cnt = 0;
    push_idle(70);
    drain(ALL, NO_LOAD, '0);
    check("reset_no_done", done_cnt, 0);

`ifdef WORK_SENDER_ABORT_EN
    // Abort at byte 5, mid data bit 1: full gap, then idle with no done.
    wa = rand_work();
    start_packet(wa);
    push_packet(wa);
    drain(5 * 10 * DIV + DIV + DIV + 3, NO_LOAD, '0);
    exp_q.delete();
    abort = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < GB * DIV; c++) exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 5));
    push_idle(3);
    drain(ALL, NO_LOAD, '0);
    check("abort_no_done", done_cnt, 0);
`endif

    // Random packets with random idle lead-in and a random stray load.
    for (int r = 0; r < 2; r++) begin
      gap = $urandom_range(0, 6);
      push_idle(gap);
      drain(ALL, NO_LOAD, '0);
      wa = rand_work();
      stray = $urandom_range(0, PKT_CYCLES - 1);
      start_packet(wa);
      push_packet(wa);
      push_idle(1);
      drain(ALL, stray, rand_work());
      check("rand_done_pulses", done_cnt, 1);
      decode_check(0, wa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
